// File: rtl/weight_stream_fetcher.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | weight_stream_fetcher                                                      |
// | Streams a runtime-sized weight matrix from BRAM as N-lane beats with bias. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module weight_stream_fetcher #(
   parameter int BRAM_WIDTH      = 64,
   parameter int PRECISION       = 8,
   parameter int N               = 4,
   parameter int BIAS_PRECISION  = 32,
   parameter int ADDR_WIDTH      = 10,
   parameter int BIAS_ADDR_WIDTH = 8,
   parameter int BRAM_LATENCY    = 2,
   parameter int FIFO_DEPTH      = 4
) (
   input  logic                       clk,
   input  logic                       clr,
   input  logic                       ce,
   input  logic                       start,
   input  logic [ADDR_WIDTH-1:0]      cfg_base_addr,
   input  logic [BIAS_ADDR_WIDTH-1:0] cfg_bias_base,
   input  logic [15:0]                cfg_rows,
   input  logic [15:0]                cfg_words_per_row,
   input  logic                       cfg_repeat,
   output logic                       w_en,
   output logic [ADDR_WIDTH-1:0]      w_addr,
   input  logic [BRAM_WIDTH-1:0]      w_rdata,
   output logic                       b_en,
   output logic [BIAS_ADDR_WIDTH-1:0] b_addr,
   input  logic [BIAS_PRECISION-1:0]  b_rdata,
   output logic [N*PRECISION-1:0]     data_out,
   output logic [BIAS_PRECISION-1:0]  bias,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic                       out_first,
   output logic                       out_last,
   output logic                       out_last_row,
   output logic                       busy,
   output logic                       done
);

   localparam int c_BEAT_W  = N * PRECISION;
   localparam int c_BPW     = BRAM_WIDTH / c_BEAT_W;
   localparam int c_BEAT_CW = (c_BPW > 1) ? $clog2(c_BPW) : 1;
   localparam int c_PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int c_CNT_W   = $clog2(FIFO_DEPTH + 1) + 1;

   localparam logic [1:0] c_IDLE  = 2'd0;
   localparam logic [1:0] c_RUN   = 2'd1;
   localparam logic [1:0] c_DRAIN = 2'd2;

   logic [1:0]                 r_state;
   logic [ADDR_WIDTH-1:0]      r_base, r_addr;
   logic [BIAS_ADDR_WIDTH-1:0] r_bias_base, r_baddr;
   logic [15:0]                r_rows, r_wpr, r_row, r_word;
   logic                       r_repeat, r_busy, r_done;

   // Flag triple everywhere below is {first_word, last_word, last_row}.
   logic                       r_pipe_vld   [BRAM_LATENCY];
   logic [2:0]                 r_pipe_flags [BRAM_LATENCY];

   logic [BRAM_WIDTH-1:0]      r_fifo_data  [FIFO_DEPTH];
   logic [BIAS_PRECISION-1:0]  r_fifo_bias  [FIFO_DEPTH];
   logic [2:0]                 r_fifo_flags [FIFO_DEPTH];
   logic [c_PTR_W-1:0]         r_wr_ptr, r_rd_ptr;
   logic [c_CNT_W-1:0]         r_count, r_inflight;
   logic [BIAS_PRECISION-1:0]  r_row_bias;
   logic [c_BEAT_CW-1:0]       r_beat;

   logic                       w_issue, w_first_word, w_last_word, w_last_row;
   logic                       w_fifo_wr, w_out_valid, w_hs, w_beat_last, w_pop, w_finish;
   logic [2:0]                 w_wr_flags, w_head_flags;
   logic [BIAS_PRECISION-1:0]  w_wr_bias;
   logic [BRAM_WIDTH-1:0]      w_head_word;
   logic [c_BEAT_W-1:0]        w_head_beat;

   function automatic logic [c_PTR_W-1:0] ptr_next(input logic [c_PTR_W-1:0] p);
      return (p == c_PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign w_first_word = (r_word == 16'd0);
   assign w_last_word  = (r_word == r_wpr - 16'd1);
   assign w_last_row   = (r_row == r_rows - 16'd1);
   // Credits cover both queued entries and reads still travelling through the BRAM.
   assign w_issue      = (r_state == c_RUN) && ce &&
                         ((r_count + r_inflight) < c_CNT_W'(FIFO_DEPTH));

   assign w_fifo_wr    = r_pipe_vld[BRAM_LATENCY-1];
   assign w_wr_flags   = r_pipe_flags[BRAM_LATENCY-1];
   assign w_wr_bias    = w_wr_flags[2] ? b_rdata : r_row_bias;

   assign w_head_word  = r_fifo_data[r_rd_ptr];
   assign w_head_flags = r_fifo_flags[r_rd_ptr];
   assign w_head_beat  = w_head_word[r_beat*c_BEAT_W +: c_BEAT_W];
   assign w_out_valid  = ce && (r_count != '0);
   assign w_hs         = w_out_valid && out_ready;
   assign w_beat_last  = (r_beat == c_BEAT_CW'(c_BPW - 1));
   assign w_pop        = w_hs && w_beat_last;
   assign w_finish     = (r_state == c_DRAIN) && w_pop && w_head_flags[1] && w_head_flags[0];

   assign w_en         = w_issue;
   assign w_addr       = r_addr;
   assign b_en         = w_issue && w_first_word;
   assign b_addr       = r_baddr;
   assign out_valid    = w_out_valid;
   assign data_out     = w_out_valid ? w_head_beat : '0;
   assign bias         = w_out_valid ? r_fifo_bias[r_rd_ptr] : '0;
   assign out_first    = w_out_valid && w_head_flags[2] && (r_beat == '0);
   assign out_last     = w_out_valid && w_head_flags[1] && w_beat_last;
   assign out_last_row = w_out_valid && w_head_flags[0];
   assign busy         = r_busy;
   assign done         = r_done;

   always_ff @(posedge clk) begin
      if (clr) begin
         r_state     <= c_IDLE;
         r_base      <= '0;
         r_addr      <= '0;
         r_bias_base <= '0;
         r_baddr     <= '0;
         r_rows      <= '0;
         r_wpr       <= '0;
         r_row       <= '0;
         r_word      <= '0;
         r_repeat    <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            c_IDLE: begin
               if (start) begin
                  r_base      <= cfg_base_addr;
                  r_addr      <= cfg_base_addr;
                  r_bias_base <= cfg_bias_base;
                  r_baddr     <= cfg_bias_base;
                  r_rows      <= cfg_rows;
                  r_wpr       <= cfg_words_per_row;
                  r_repeat    <= cfg_repeat;
                  r_row       <= '0;
                  r_word      <= '0;
                  r_busy      <= 1'b1;
                  if (cfg_rows == 16'd0 || cfg_words_per_row == 16'd0) begin
                     r_done <= 1'b1;
                  end else begin
                     r_state <= c_RUN;
                  end
               end else begin
                  r_busy <= 1'b0;
               end
            end
            c_RUN: begin
               if (w_issue) begin
                  r_addr <= r_addr + 1'b1;
                  if (w_last_word) begin
                     r_word <= '0;
                     if (w_last_row) begin
                        if (r_repeat) begin
                           r_row   <= '0;
                           r_addr  <= r_base;
                           r_baddr <= r_bias_base;
                        end else begin
                           r_state <= c_DRAIN;
                        end
                     end else begin
                        r_row   <= r_row + 16'd1;
                        r_baddr <= r_baddr + 1'b1;
                     end
                  end else begin
                     r_word <= r_word + 16'd1;
                  end
               end
            end
            c_DRAIN: begin
               if (w_finish) begin
                  r_state <= c_IDLE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end
            end
            default: r_state <= c_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         for (int k = 0; k < BRAM_LATENCY; k++) begin
            r_pipe_vld[k]   <= 1'b0;
            r_pipe_flags[k] <= '0;
         end
         for (int e = 0; e < FIFO_DEPTH; e++) begin
            r_fifo_data[e]  <= '0;
            r_fifo_bias[e]  <= '0;
            r_fifo_flags[e] <= '0;
         end
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_inflight <= '0;
         r_row_bias <= '0;
         r_beat     <= '0;
      end else begin
         r_pipe_vld[0]   <= w_issue;
         r_pipe_flags[0] <= {w_first_word, w_last_word, w_last_row};
         for (int k = 1; k < BRAM_LATENCY; k++) begin
            r_pipe_vld[k]   <= r_pipe_vld[k-1];
            r_pipe_flags[k] <= r_pipe_flags[k-1];
         end

         if (w_fifo_wr) begin
            r_fifo_data[r_wr_ptr]  <= w_rdata;
            r_fifo_bias[r_wr_ptr]  <= w_wr_bias;
            r_fifo_flags[r_wr_ptr] <= w_wr_flags;
            r_wr_ptr               <= ptr_next(r_wr_ptr);
            if (w_wr_flags[2]) begin
               r_row_bias <= b_rdata;
            end
         end

         if (w_pop) begin
            r_rd_ptr <= ptr_next(r_rd_ptr);
            r_beat   <= '0;
         end else if (w_hs) begin
            r_beat <= r_beat + 1'b1;
         end

         case ({w_fifo_wr, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase

         case ({w_issue, w_fifo_wr})
            2'b10:   r_inflight <= r_inflight + 1'b1;
            2'b01:   r_inflight <= r_inflight - 1'b1;
            default: r_inflight <= r_inflight;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_weight_stream_fetcher.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_weight_stream_fetcher                                                   |
// | Directed vector bench with BRAM/bias memory models for the fetcher.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_weight_stream_fetcher;

   localparam int c_BW    = 64;
   localparam int c_AW    = 10;
   localparam int c_BAW   = 8;
   localparam int c_LAT   = 2;
   localparam int c_DEPTH = 4;
   localparam int c_BPW   = 2;

   typedef struct packed {
      int rows;
      int wpr;
      bit rep;
      int pct;
      int gap_at;
      int nbeats;
      bit exp_done;
   } vec_t;

   logic              clk = 1'b0;
   logic              clr, ce, start, cfg_repeat, out_ready;
   logic [c_AW-1:0]   cfg_base_addr;
   logic [c_BAW-1:0]  cfg_bias_base;
   logic [15:0]       cfg_rows, cfg_words_per_row;
   logic              w_en, b_en, out_valid, out_first, out_last, out_last_row, busy, done;
   logic [c_AW-1:0]   w_addr;
   logic [c_BAW-1:0]  b_addr;
   logic [c_BW-1:0]   w_rdata;
   logic [31:0]       b_rdata, data_out, bias;

   logic [c_BW-1:0]   r_wpipe [c_LAT];
   logic [31:0]       r_bpipe [c_LAT];

   int                n_checks = 0;
   int                n_fail   = 0;
   vec_t              vecs [7];

   always #5 clk = ~clk;

   weight_stream_fetcher dut (
      .clk(clk), .clr(clr), .ce(ce), .start(start),
      .cfg_base_addr(cfg_base_addr), .cfg_bias_base(cfg_bias_base),
      .cfg_rows(cfg_rows), .cfg_words_per_row(cfg_words_per_row), .cfg_repeat(cfg_repeat),
      .w_en(w_en), .w_addr(w_addr), .w_rdata(w_rdata),
      .b_en(b_en), .b_addr(b_addr), .b_rdata(b_rdata),
      .data_out(data_out), .bias(bias), .out_valid(out_valid), .out_ready(out_ready),
      .out_first(out_first), .out_last(out_last), .out_last_row(out_last_row),
      .busy(busy), .done(done)
   );

   function automatic logic [c_BW-1:0] word_of(input logic [c_AW-1:0] a);
      logic [c_BW-1:0] w;
      for (int b = 0; b < 8; b++) w[b*8 +: 8] = 8'((int'(a) * 8 + b) & 255);
      return w;
   endfunction

   function automatic logic [31:0] exp_lanes(input int k, input int j);
      logic [31:0] v;
      for (int i = 0; i < 4; i++) v[i*8 +: 8] = 8'((k * 8 + j * 4 + i) & 255);
      return v;
   endfunction

   // Memories return data BRAM_LATENCY edges after the enable is sampled.
   always @(posedge clk) begin
      r_wpipe[0] <= w_en ? word_of(w_addr) : {16{4'hE}};
      r_bpipe[0] <= b_en ? 32'(1000 + int'(b_addr)) : 32'hBAD0_BAD0;
      for (int k = 1; k < c_LAT; k++) begin
         r_wpipe[k] <= r_wpipe[k-1];
         r_bpipe[k] <= r_bpipe[k-1];
      end
   end
   assign w_rdata = r_wpipe[c_LAT-1];
   assign b_rdata = r_bpipe[c_LAT-1];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   task automatic run_vec(input vec_t v);
      int got, cyc, issued, popped, maxout, first_valid, gap_left, gap_cycles;
      int gap_viol, stab_bad, busy_bad, ndone, hold_bad, k, j, row, wr;
      bit gap_done, prev_stall;
      logic [31:0] h_data, h_bias;
      logic [2:0]  h_flags;
      got = 0; cyc = 1; issued = 0; popped = 0; maxout = 0; first_valid = -1;
      gap_left = 0; gap_cycles = 0; gap_viol = 0; stab_bad = 0; busy_bad = 0;
      ndone = 0; hold_bad = 0; gap_done = 1'b0; prev_stall = 1'b0;
      h_data = '0; h_bias = '0; h_flags = '0;

      @(posedge clk); #1;
      cfg_rows = 16'(v.rows); cfg_words_per_row = 16'(v.wpr); cfg_repeat = v.rep;
      cfg_base_addr = '0; cfg_bias_base = '0; ce = 1'b1; out_ready = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;

      while (got < v.nbeats && cyc < 3000) begin
         if (!gap_done && v.gap_at >= 0 && got == v.gap_at) begin
            gap_left = 5;
            gap_done = 1'b1;
         end
         ce = (gap_left == 0);
         out_ready = (int'($urandom_range(99)) < v.pct);
         @(negedge clk);
         if (w_en) issued++;
         if (issued - popped > maxout) maxout = issued - popped;
         if (!ce) begin
            gap_cycles++;
            if (w_en || out_valid) gap_viol++;
         end
         if (busy !== 1'b1) busy_bad++;
         if (done) ndone++;
         if (out_valid && first_valid < 0) first_valid = cyc;
         if (prev_stall && ce) begin
            if (!out_valid || data_out !== h_data || bias !== h_bias ||
                {out_first, out_last, out_last_row} !== h_flags) stab_bad++;
         end
         if (out_valid && out_ready) begin
            k   = (got / c_BPW) % (v.rows * v.wpr);
            j   = got % c_BPW;
            row = k / v.wpr;
            wr  = k % v.wpr;
            check("beat_data", data_out, exp_lanes(k, j));
            check("beat_bias", bias, 32'(1000 + row));
            check("beat_flags", {out_first, out_last, out_last_row},
                  {(wr == 0 && j == 0), (wr == v.wpr - 1 && j == c_BPW - 1), (row == v.rows - 1)});
            got++;
            if (got % c_BPW == 0) popped++;
         end
         prev_stall = out_valid && !out_ready;
         h_data = data_out; h_bias = bias; h_flags = {out_first, out_last, out_last_row};
         @(posedge clk); #1;
         if (gap_left > 0) gap_left--;
         cyc++;
      end

      check("beat_count", got, v.nbeats);
      check("first_valid_cycle", first_valid, c_LAT + 2);
      check("outstanding_within_depth", maxout <= c_DEPTH, 1);
      check("stall_hold", stab_bad, 0);
      check("busy_during_run", busy_bad, 0);
      check("early_done", ndone, 0);
      if (v.gap_at >= 0) begin
         check("ce_gap_cycles", gap_cycles, 5);
         check("ce_gap_quiet", gap_viol, 0);
      end

      ce = 1'b1; out_ready = 1'b1;
      if (v.exp_done) begin
         @(negedge clk);
         check("done_pulse", done, 1);
         check("busy_after_done", busy, 0);
         @(posedge clk); #1;
         @(negedge clk);
         check("done_single_cycle", done, 0);
         check("no_reads_after_done", w_en, 0);
      end else begin
         if (v.rep) begin
            for (int c = 0; c < 8; c++) begin
               @(negedge clk);
               if (done || !busy) hold_bad++;
               @(posedge clk); #1;
            end
            check("repeat_busy_no_done", hold_bad, 0);
         end
         clr = 1'b1;
         @(posedge clk); #1;
         clr = 1'b0;
         @(negedge clk);
         check("clr_out_valid", out_valid, 0);
         check("clr_busy", busy, 0);
         check("clr_w_en", w_en, 0);
         hold_bad = 0;
         for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (out_valid || w_en) hold_bad++;
         end
         check("clr_stale_ignored", hold_bad, 0);
      end
   endtask

   initial begin
      int wen_seen;
      vecs[0] = '{rows:6, wpr:2, rep:1'b0, pct:100, gap_at:-1, nbeats:24, exp_done:1'b1};
      vecs[1] = '{rows:6, wpr:2, rep:1'b0, pct:50,  gap_at:-1, nbeats:24, exp_done:1'b1};
      vecs[2] = '{rows:2, wpr:2, rep:1'b1, pct:100, gap_at:-1, nbeats:40, exp_done:1'b0};
      vecs[3] = '{rows:6, wpr:2, rep:1'b0, pct:100, gap_at:-1, nbeats:10, exp_done:1'b0};
      vecs[4] = '{rows:6, wpr:2, rep:1'b0, pct:100, gap_at:-1, nbeats:24, exp_done:1'b1};
      vecs[5] = '{rows:3, wpr:3, rep:1'b0, pct:100, gap_at:7,  nbeats:18, exp_done:1'b1};
      vecs[6] = '{rows:1, wpr:1, rep:1'b0, pct:60,  gap_at:-1, nbeats:2,  exp_done:1'b1};

      // Reset held with start and ce asserted: clr must win.
      clr = 1'b1; ce = 1'b1; start = 1'b1; out_ready = 1'b1; cfg_repeat = 1'b0;
      cfg_base_addr = '0; cfg_bias_base = '0; cfg_rows = 16'd6; cfg_words_per_row = 16'd2;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_w_en", w_en, 0);
      check("rst_b_en", b_en, 0);
      check("rst_w_addr", w_addr, 0);
      check("rst_b_addr", b_addr, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_data_out", data_out, 0);
      check("rst_bias", bias, 0);
      check("rst_flags", {out_first, out_last, out_last_row}, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      @(posedge clk); #1;
      clr = 1'b0; start = 1'b0;

      for (int i = 0; i < 7; i++) run_vec(vecs[i]);

      // Degenerate geometries complete immediately without touching memory.
      for (int z = 0; z < 2; z++) begin
         wen_seen = 0;
         @(posedge clk); #1;
         cfg_rows = (z == 0) ? 16'd0 : 16'd3;
         cfg_words_per_row = (z == 0) ? 16'd2 : 16'd0;
         start = 1'b1;
         @(posedge clk); #1;
         start = 1'b0;
         @(negedge clk);
         check("zero_done", done, 1);
         check("zero_busy", busy, 1);
         if (w_en) wen_seen++;
         for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (c == 0) begin
               check("zero_done_clears", done, 0);
               check("zero_busy_clears", busy, 0);
            end
            if (w_en || out_valid) wen_seen++;
         end
         check("zero_no_reads", wen_seen, 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire

// File: doc/weight_stream_fetcher.md
Name: weight_stream_fetcher

Overview:
Parametrised successor to the fixed-geometry weight fetcher. It streams a runtime-configured weight matrix from an external synchronous BRAM. Each BRAM word is unpacked into N-lane beats and paired with the per-row bias from a separate bias memory. Beats feed the linear-layer MAC array over a valid/ready handshake, with prefetch buffering, backpressure, and an optional repeat mode for back-to-back input vectors.

Parameters:
BRAM_WIDTH, 64, weight BRAM word width; must be a multiple of N*PRECISION
PRECISION, 8, bits per weight
N, 4, lanes per output beat
BIAS_PRECISION, 32, bias width
ADDR_WIDTH, 10, weight BRAM address width
BIAS_ADDR_WIDTH, 8, bias memory address width
BRAM_LATENCY, 2, read latency (en to rdata) of both memories, in cycles, >=1
FIFO_DEPTH, 4, prefetch FIFO entries; must be >= BRAM_LATENCY+1

Ports:
clk  in  1  clock
clr  in  1  synchronous active-high reset
ce  in  1  clock enable for read issue and output handshake
start  in  1  one-cycle pulse; samples cfg_* when idle
cfg_base_addr  in  ADDR_WIDTH  first weight word address
cfg_bias_base  in  BIAS_ADDR_WIDTH  bias address of row 0
cfg_rows  in  16  number of rows (M)
cfg_words_per_row  in  16  BRAM words per row
cfg_repeat  in  1  1 = wrap to row 0 endlessly
w_en  out  1  weight read enable
w_addr  out  ADDR_WIDTH  weight read address
w_rdata  in  BRAM_WIDTH  weight read data
b_en  out  1  bias read enable
b_addr  out  BIAS_ADDR_WIDTH  bias read address
b_rdata  in  BIAS_PRECISION  bias read data
data_out  out  [N-1:0] x PRECISION  beat lanes
bias  out  BIAS_PRECISION  bias of current row
out_valid  out  1  beat valid
out_ready  in  1  consumer ready
out_first  out  1  first beat of a row
out_last  out  1  last beat of a row
out_last_row  out  1  beat belongs to final row
busy  out  1  run in progress
done  out  1  one-cycle completion pulse

Behaviour:
- Reset (clr=1 at a rising edge): all registers cleared. Outputs after reset: w_en=b_en=0, w_addr=b_addr=0, out_valid=0, data_out=0, bias=0, flags=0, busy=0, done=0. FIFO is flushed. The read-valid pipeline is cleared, so data from in-flight reads is discarded. clr overrides start and ce.
- Derived constant: BPW = BRAM_WIDTH/(N*PRECISION) beats per word. For beat j, lane i = word[(j*N+i)*PRECISION +: PRECISION]. Beat 0 is emitted first.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE: start=1 latches cfg and sets busy=1 the next cycle. If cfg_rows=0 or cfg_words_per_row=0: done pulses the next cycle, no reads are issued, state stays IDLE. Otherwise go to RUN.
  - In RUN or DRAIN, start is ignored.
- RUN, read issue:
  - A read issues when ce=1 and (FIFO count + in-flight reads) < FIFO_DEPTH. w_en=1 with w_addr = base + linear word index.
  - b_en=1 only on the first word of each row, with b_addr = cfg_bias_base + row.
  - The first issue occurs the cycle after start.
  - Address counters wrap only through cfg: after the last word of the last row, cfg_repeat=1 restarts at cfg_base_addr, row 0. cfg_repeat=0 goes to DRAIN.
- Read pipeline: a shift register of BRAM_LATENCY stages carries {valid, first_word, last_word, last_row} per read and advances every cycle regardless of ce. Returned data is written into the FIFO together with its flags. Bias is captured on first_word and stored with every entry of that row.
- Output:
  - out_valid = ce && FIFO non-empty. data_out and bias are forced to 0 when out_valid=0.
  - A beat counter advances on out_valid && out_ready. The FIFO pops when the counter = BPW-1; the counter then returns to 0.
  - out_first = head.first_word && beat==0. out_last = head.last_word && beat==BPW-1. out_last_row = head.last_row.
  - Outputs are stable while out_valid && !out_ready.
- Latency: with ce=1, out_ready=1 and start accepted at edge 0, the first out_valid is at cycle BRAM_LATENCY+2 (cycle 4 at defaults).
- Throughput: sustained at one beat per cycle.
- DRAIN: no further reads. On the handshake of the beat with out_last && out_last_row, done=1 for exactly one cycle the following cycle, busy=0, state returns to IDLE. With cfg_repeat=1, done never pulses; only clr terminates the run.
- ce=0: no reads issued and no handshakes, but in-flight reads still land in the FIFO; credits guarantee space for them. No beat is lost or duplicated across ce toggles.
- Address arithmetic is modulo 2^ADDR_WIDTH and 2^BIAS_ADDR_WIDTH.

Test Plan:
1. Defaults; memory word k holds bytes k*8+0..7; b_mem[r]=1000+r; rows=6, words_per_row=2, repeat=0, out_ready=1 -> exactly 24 beats.
   - Beat 0 lanes = {0,1,2,3}, beat 1 = {4,5,6,7}.
   - out_first on beats 0,4,8..; out_last on beats 3,7..; out_last_row on beats 20-23.
   - bias=1000+row; done pulses once.
2. Same config with out_ready random 50% -> identical beat sequence; in-flight reads plus FIFO count never exceed 4; data held stable while stalled.
3. rows=2, repeat=1, run 40 beats -> beat 8 has out_first=1 with row-0 data and bias=1000; done stays 0; busy stays 1.
4. clr for 1 cycle after 10 beats, then start again -> out_valid=0, busy=0, FIFO empty the cycle after clr; stale BRAM data ignored; the restart reproduces beat 0 = {0,1,2,3}.
5. ce=0 for 5 cycles mid-row -> no w_en, out_valid=0; after ce returns, the beat sequence continues with no gap or duplicate.
6. cfg_rows=0 with start -> done=1 one cycle later; w_en never asserted; busy returns to 0.
